// File: rtl/matrix_feeder_if.sv
// Host/multiplier-facing bundle of the matrix_feeder operand source.
// The master side is the host plus multiplier; the slave side is the feeder.
interface matrix_feeder_if #(
    parameter int DW = 16
);
    logic                 [3:0] sizes;
    logic                       wr_en;
    logic                       wr_bank;
    logic                 [5:0] wr_idx;
    logic signed     [DW-1:0] wr_data;
    logic                       go;
    logic                       start;
    logic                       ren;
    logic                       raddr;
    logic signed     [DW-1:0] rdata;
    logic                       finish;
    logic                       busy;
    logic                       err;

    modport master (
        output sizes, wr_en, wr_bank, wr_idx, wr_data, go, ren, raddr, finish,
        input  start, rdata, busy, err
    );

    modport slave (
        input  sizes, wr_en, wr_bank, wr_idx, wr_data, go, ren, raddr, finish,
        output start, rdata, busy, err
    );
endinterface

// File: rtl/matrix_feeder.sv
// Two-bank operand store feeding a 6x6 matrix multiplier with zero-latency reads.
// Optional macro FEEDER_CLEAR_ON_FINISH_EN zeroes both banks when finish is accepted.
module matrix_feeder #(
    parameter int MAX_SIZE = 6,
    parameter int DW       = 16
) (
    input logic             clk,
    input logic             rst,
    matrix_feeder_if.slave  bus
);
    localparam int         DEPTH   = MAX_SIZE * MAX_SIZE;
    localparam logic [5:0] DEPTH_W = 6'(DEPTH);
    localparam logic [3:0] MAX_N   = 4'(MAX_SIZE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM      = 2'd1,
        STREAM   = 2'd2,
        WAIT_FIN = 2'd3
    } state_t;

    state_t                state_r;
    logic           [5:0]  ptr_a_r;
    logic           [5:0]  ptr_b_r;
    logic           [5:0]  n_sq_r;
    logic                  start_r;
    logic                  busy_r;
    logic                  err_r;
    logic signed [DW-1:0]  bank_a_r [DEPTH];
    logic signed [DW-1:0]  bank_b_r [DEPTH];

    logic           [5:0]  sq_s;
    logic           [5:0]  ptr_sel_s;
    logic                  avail_s;
    logic                  rd_fire_s;
    logic           [5:0]  ptr_a_nx_s;
    logic           [5:0]  ptr_b_nx_s;
    logic                  wr_ok_s;
    logic                  wr_bad_s;
    logic                  go_ok_s;
    logic                  go_bad_s;
    logic                  fin_ok_s;
    logic                  err_set_s;
    logic signed [DW-1:0]  rdata_s;

    assign sq_s      = {2'b00, bus.sizes} * {2'b00, bus.sizes};
    assign ptr_sel_s = bus.raddr ? ptr_b_r : ptr_a_r;
    assign avail_s   = (ptr_sel_s < n_sq_r);
    assign rd_fire_s = (state_r == STREAM) && bus.ren;
    assign wr_ok_s   = (state_r == IDLE) && bus.wr_en && (bus.wr_idx < DEPTH_W);
    assign wr_bad_s  = bus.wr_en && !wr_ok_s;
    assign go_ok_s   = (state_r == IDLE) && bus.go && (bus.sizes != 4'd0) && (bus.sizes <= MAX_N);
    assign go_bad_s  = (state_r == IDLE) && bus.go && !go_ok_s;
    assign fin_ok_s  = bus.finish && ((state_r == STREAM) || (state_r == WAIT_FIN));
    // Early finish in STREAM is always premature: pointers completing leave STREAM on that edge.
    assign err_set_s = wr_bad_s || go_bad_s || (rd_fire_s && !avail_s)
                       || (bus.finish && (state_r == STREAM));

    // Pointer advance for the bank the multiplier is reading; overruns hold the pointer.
    always_comb begin
        ptr_a_nx_s = ptr_a_r;
        ptr_b_nx_s = ptr_b_r;
        if (rd_fire_s && avail_s) begin
            if (bus.raddr) begin
                ptr_b_nx_s = ptr_b_r + 6'd1;
            end else begin
                ptr_a_nx_s = ptr_a_r + 6'd1;
            end
        end else begin
            ptr_a_nx_s = ptr_a_r;
            ptr_b_nx_s = ptr_b_r;
        end
    end

    // Zero-latency read data path.
    always_comb begin
        rdata_s = '0;
        if (rd_fire_s && avail_s) begin
            rdata_s = bus.raddr ? bank_b_r[ptr_sel_s] : bank_a_r[ptr_sel_s];
        end else begin
            rdata_s = '0;
        end
    end

    assign bus.rdata = rdata_s;
    assign bus.start = start_r;
    assign bus.busy  = busy_r;
    assign bus.err   = err_r;

    // Control FSM with registered start/busy/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_a_r <= 6'd0;
            ptr_b_r <= 6'd0;
            n_sq_r  <= 6'd0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            start_r <= 1'b0;
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (go_ok_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            case (state_r)
                IDLE: begin
                    if (go_ok_s) begin
                        state_r <= ARM;
                        n_sq_r  <= sq_s;
                        ptr_a_r <= 6'd0;
                        ptr_b_r <= 6'd0;
                        start_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARM: begin
                    state_r <= STREAM;
                end
                STREAM: begin
                    if (bus.finish) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        ptr_a_r <= ptr_a_nx_s;
                        ptr_b_r <= ptr_b_nx_s;
                        if ((ptr_a_nx_s == n_sq_r) && (ptr_b_nx_s == n_sq_r)) begin
                            state_r <= WAIT_FIN;
                        end else begin
                            state_r <= STREAM;
                        end
                    end
                end
                WAIT_FIN: begin
                    if (bus.finish) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_FIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Operand banks: host writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_a_r[i] <= '0;
                bank_b_r[i] <= '0;
            end
`ifdef FEEDER_CLEAR_ON_FINISH_EN
        end else if (fin_ok_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_a_r[i] <= '0;
                bank_b_r[i] <= '0;
            end
`endif
        end else if (wr_ok_s) begin
            if (bus.wr_bank) begin
                bank_b_r[bus.wr_idx] <= bus.wr_data;
            end else begin
                bank_a_r[bus.wr_idx] <= bus.wr_data;
            end
        end else begin
            bank_a_r <= bank_a_r;
            bank_b_r <= bank_b_r;
        end
    end

    // Keeps fin_ok_s meaningful in builds without bank clearing.
    logic fin_seen_unused_s;
    assign fin_seen_unused_s = fin_ok_s;
endmodule

// File: tb/tb_matrix_feeder.sv
// Directed self-checking bench for matrix_feeder; expectations are hand-computed.
module tb_matrix_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   miss = 0;

`ifdef FEEDER_CLEAR_ON_FINISH_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    matrix_feeder_if #(.DW(16)) bus ();

    matrix_feeder #(.MAX_SIZE(6), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic b, input logic [5:0] idx, input logic signed [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_bank = b;
        bus.wr_idx  = idx;
        bus.wr_data = d;
        cyc();
        bus.wr_en   = 1'b0;
    endtask

    task automatic go_run(input logic [3:0] n);
        bus.sizes = n;
        bus.go    = 1'b1;
        cyc();
        bus.go    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic sel, input logic signed [15:0] exp);
        bus.ren   = 1'b1;
        bus.raddr = sel;
        #1;
        chk(tag, bus.rdata, exp);
        cyc();
        bus.ren   = 1'b0;
    endtask

    task automatic fin();
        bus.finish = 1'b1;
        cyc();
        bus.finish = 1'b0;
    endtask

    initial begin
        bus.sizes = 4'd0; bus.wr_en = 1'b0; bus.wr_bank = 1'b0; bus.wr_idx = 6'd0;
        bus.wr_data = 16'sd0; bus.go = 1'b0; bus.ren = 1'b0; bus.raddr = 1'b0; bus.finish = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_start", bus.start, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        bus.ren = 1'b1; #1;
        chk("idle_rdata", bus.rdata, 16'sd0);
        bus.ren = 1'b0;

        // Normal run, n=2
        for (int i = 0; i < 4; i++) wr(1'b0, 6'(i), 16'(i + 1));
        for (int i = 0; i < 4; i++) wr(1'b1, 6'(i), 16'(i + 5));
        go_run(4'd2);
        chk("go_start", bus.start, 1'b1);
        chk("go_busy", bus.busy, 1'b1);
        cyc();
        chk("arm_start_low", bus.start, 1'b0);
        for (int i = 0; i < 4; i++) rd("n2_a", 1'b0, 16'(i + 1));
        for (int i = 0; i < 4; i++) rd("n2_b", 1'b1, 16'(i + 5));
        chk("n2_wait_busy", bus.busy, 1'b1);
        chk("n2_err", bus.err, 1'b0);
        fin();
        chk("n2_fin_busy", bus.busy, 1'b0);
        chk("n2_fin_err", bus.err, 1'b0);

        // Rerun without reloading: banks persist unless cleared on finish
        go_run(4'd2);
        cyc();
        for (int i = 0; i < 4; i++) rd("rerun_a", 1'b0, CLR ? 16'sd0 : 16'(i + 1));
        for (int i = 0; i < 4; i++) rd("rerun_b", 1'b1, CLR ? 16'sd0 : 16'(i + 5));
        fin();

        // Bad sizes
        go_run(4'd0);
        chk("sz0_err", bus.err, 1'b1);
        chk("sz0_start", bus.start, 1'b0);
        chk("sz0_busy", bus.busy, 1'b0);
        go_run(4'd7);
        chk("sz7_err", bus.err, 1'b1);
        chk("sz7_start", bus.start, 1'b0);
        chk("sz7_busy", bus.busy, 1'b0);
        go_run(4'd3);
        chk("sz3_err_clr", bus.err, 1'b0);
        chk("sz3_start", bus.start, 1'b1);
        cyc();
        fin();
        chk("early_fin_err", bus.err, 1'b1);
        chk("early_fin_busy", bus.busy, 1'b0);

        // Overrun, n=1
        wr(1'b0, 6'd0, -16'sd3);
        go_run(4'd1);
        cyc();
        rd("ovr_first", 1'b0, -16'sd3);
        bus.ren = 1'b1; bus.raddr = 1'b0; #1;
        chk("ovr_rdata", bus.rdata, 16'sd0);
        cyc();
        bus.ren = 1'b0;
        chk("ovr_err", bus.err, 1'b1);
        fin();
        chk("ovr_fin_busy", bus.busy, 1'b0);

        // Write while busy
        wr(1'b0, 6'd0, -16'sd3);
        wr(1'b1, 6'd0, 16'sd5);
        go_run(4'd1);
        cyc();
        chk("wb_err_before", bus.err, 1'b0);
        wr(1'b0, 6'd0, 16'sd99);
        chk("wb_err", bus.err, 1'b1);
        rd("wb_a0", 1'b0, -16'sd3);
        rd("wb_b0", 1'b1, 16'sd5);
        fin();
        go_run(4'd1);
        cyc();
        rd("persist_a0", 1'b0, CLR ? 16'sd0 : -16'sd3);
        rd("persist_b0", 1'b1, CLR ? 16'sd0 : 16'sd5);
        fin();

        // Reset mid-stream, n=6
        for (int i = 0; i < 36; i++) wr(1'b0, 6'(i), 16'(100 + i));
        go_run(4'd6);
        cyc();
        for (int i = 0; i < 10; i++) rd("n6_a", 1'b0, 16'(100 + i));
        bus.ren = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_start", bus.start, 1'b0);
        #1;
        chk("mrst_rdata", bus.rdata, 16'sd0);
        bus.ren = 1'b0;
        wr(1'b0, 6'd0, 16'sd7);
        wr(1'b0, 6'd1, 16'sd8);
        go_run(4'd6);
        cyc();
        rd("post_rst_a0", 1'b0, 16'sd7);
        rd("post_rst_a1", 1'b0, 16'sd8);
        rd("rst_cleared_a2", 1'b0, 16'sd0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Out-of-range write index in IDLE
        chk("idx_err_before", bus.err, 1'b0);
        wr(1'b0, 6'd36, 16'sd1);
        chk("idx36_err", bus.err, 1'b1);
        go_run(4'd1);
        chk("idx_go_clr", bus.err, 1'b0);
        cyc();
        rd("idx36_a0", 1'b0, 16'sd7 - 16'sd7);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/matrix_feeder.md
# matrix_feeder

Operand source placed directly upstream of the 6x6 16-bit matrix multiplier. The host loads matrices A and B element by element into two internal banks and then issues `go`. The block pulses `start` to the multiplier and serves its `ren`/`raddr` read stream with zero-latency `rdata`, one element per cycle. It holds off new loads until the multiplier reports `finish`.

## Interface
- `MAX_SIZE`, 6: maximum matrix dimension; each bank holds MAX_SIZE*MAX_SIZE words.
- `DW`, 16: element width, two's-complement signed.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `sizes`  in  4: matrix dimension n; sampled only on an accepted `go`.
- `wr_en`  in  1: host element write strobe.
- `wr_bank`  in  1: write target; 0 = A, 1 = B.
- `wr_idx`  in  6: element index 0..MAX_SIZE²-1.
- `wr_data`  in  DW: element value.
- `go`  in  1: host request to start a multiply.
- `start`  out  1: one-cycle pulse to the multiplier.
- `ren`  in  1: read enable from the multiplier.
- `raddr`  in  1: bank select from the multiplier; 0 = A, 1 = B.
- `rdata`  out  DW signed: element presented to the multiplier.
- `finish`  in  1: multiplier done pulse.
- `busy`  out  1: high in every state except IDLE.
- `err`  out  1: sticky error flag; cleared by `rst` or by an accepted `go`.

## Operation
- States:
  - IDLE: loading allowed.
  - ARM: `start`=1 for exactly one cycle.
  - STREAM: serving reads.
  - WAIT_FIN: waiting for `finish`.
- IDLE:
  - `wr_en`=1 with `wr_idx` < MAX_SIZE² writes `wr_data` into the selected bank.
  - `wr_idx` ≥ MAX_SIZE² drops the write and sets `err`.
- `wr_en` outside IDLE: write dropped, `err` set.
- `go` in IDLE with 1 ≤ `sizes` ≤ MAX_SIZE:
  - latch n, clear `err`, zero both read pointers `ptrA` and `ptrB`, go to ARM.
  - Otherwise (n = 0 or n > MAX_SIZE): set `err`, stay in IDLE, no `start`.
- `wr_en` and `go` on the same edge in IDLE: the write is performed and included in the stream.
- ARM → STREAM unconditionally after one cycle.
- STREAM:
  - `rdata` = bank[`raddr`][ptr[`raddr`]], combinational, whenever `ren`=1.
  - The selected pointer increments on each rising edge with `ren`=1.
  - Elements stream in ascending index order 0..n²-1. Element layout is the host's responsibility.
- Overrun: `ren`=1 with ptr[`raddr`] = n² drives `rdata`=0, sets `err`, and leaves the pointer unchanged.
- STREAM → WAIT_FIN on the edge where both pointers equal n².
- `finish`=1 in STREAM or WAIT_FIN → IDLE. An early `finish` in STREAM also sets `err`.
- `finish` or `go` in any other state is ignored.
- `rdata`=0 whenever `ren`=0 or the state is not STREAM.
- `ren` outside STREAM has no effect.
- Bank contents persist across runs unless the option under Configuration is compiled in.

## Timing
- Reset values: state IDLE; `start`=0, `rdata`=0, `busy`=0, `err`=0; both pointers 0; all bank words 0.
- `rst` takes priority over all other inputs, including mid-stream. The next cycle is IDLE with empty pointers.
- `go` accepted at edge T: `start`=1 during cycle T..T+1, and `busy`=1 from T onward.
- Zero read latency: `rdata` is valid in the same cycle `ren` is high, so it can be sampled on the falling edge.
- Throughput: one element per cycle. Loading n² A elements then n² B elements takes 2n² consecutive `ren` cycles.
- `finish` sampled at edge F: `busy`=0 from F onward, and a new `go` is accepted at F+1.
- `start`, `busy` and `err` are decoded from registers only; there is no combinational path from inputs.

## Configuration
- `FEEDER_CLEAR_ON_FINISH_EN`
  - Defined: the edge that accepts `finish` also zeroes every word of both banks.
  - Undefined: banks retain contents, so back-to-back runs may reuse an operand bank without reloading.

## Test plan
- Normal run, n=2: load A={1,2,3,4} and B={5,6,7,8}, `go` → one `start` pulse.
  - 4 `ren` cycles with `raddr`=0 yield 1,2,3,4; 4 cycles with `raddr`=1 yield 5,6,7,8.
  - `finish` → `busy`=0, `err`=0.
- Bad size: `sizes`=0 then `sizes`=7 with `go` → `err`=1, no `start`, state stays IDLE.
  - Subsequent valid `go` with n=3 clears `err`.
- Overrun, n=1: A={-3}. Two `ren` cycles with `raddr`=0 → `rdata`=-3, then 0 with `err`=1.
- Write while busy: `wr_en` with idx 0, data 99 during STREAM → dropped, `err`=1.
  - After `finish`, bank A[0] still holds the old value.
- Reset mid-stream, n=6: assert `rst` after 10 reads → `busy`=0, `rdata`=0.
  - A new `go` streams from index 0.
- Macro check: with `FEEDER_CLEAR_ON_FINISH_EN` defined, rerun without reloading → all reads return 0.
  - Without the macro, the rerun returns the previous values.
